bp_be_cfg_reg_ctrl: RTL and testbench
=====================================

# bp_be_cfg_reg_ctrl

Arbitrated access controller for a single 64-bit backend configuration register with a non-zero reset value. Up to `num_req_p` requesters issue write, set, clear or read operations. The block grants one request at a time in round-robin order and applies it read-modify-write under a legal-bit mask. It returns the pre-update value, matching CSR-instruction semantics. It sits in the backend between CSR/trap/debug sources and the register; `cfg_o` feeds downstream consumers directly.

## Interface
Parameters:
- `width_p`, 64, register width
- `num_req_p`, 2, number of requesters (≥2)
- `reset_val_p`, 64'h0000_0000_8000_0124, register value after reset
- `legal_mask_p`, 64'hFFFF_FFFF_FFFF_FFFF, bits writable by requesters; other bits hold their reset value

Ports:
- `clk_i`  in  1  single clock
- `reset_i`  in  1  synchronous, active-high reset
- `req_v_i`  in  num_req_p  request valid, one per requester
- `req_op_i`  in  num_req_p×2  op per requester: WRITE=0, SET=1, CLEAR=2, READ=3
- `req_data_i`  in  num_req_p×width_p  operand per requester
- `req_yumi_o`  out  num_req_p  one-hot grant/accept; requester drops or advances its request on the next cycle
- `resp_v_o`  out  1  response valid
- `resp_id_o`  out  $clog2(num_req_p)  index of the granted requester
- `resp_data_o`  out  width_p  register value before the operation
- `resp_ready_i`  in  1  response consumer ready
- `cfg_o`  out  width_p  current register value

## Operation
- States: IDLE, COMMIT, RESP.
- IDLE: if any `req_v_i` is set, grant one via round-robin, assert its `req_yumi_o`, and capture op, data and id. Go to COMMIT. Otherwise stay in IDLE.
- COMMIT: compute `nxt` from the current value `old`:
  - WRITE: `nxt = d`
  - SET: `nxt = old | d`
  - CLEAR: `nxt = old & ~d`
  - Final value: `(old & ~legal_mask_p) | (nxt & legal_mask_p)`.
  - Register enable is asserted for one cycle, except for READ, where enable stays low.
  - Capture `old` into `resp_data_o`. Go to RESP.
- RESP: `resp_v_o`=1. If `resp_ready_i` is low, hold all response outputs stable and accept no request.
  - If `resp_ready_i` is high and a request is valid, grant it in the same cycle and go to COMMIT.
  - If `resp_ready_i` is high and no request is valid, go to IDLE.
- Round-robin: after a grant to requester k, requester k+1 (mod num_req_p) has highest priority. After reset, requester 0 has highest priority.
- `req_yumi_o` depends combinationally on `req_v_i`, state and `resp_ready_i`. It never depends combinationally on `req_op_i` or `req_data_i`.
- At most one `req_yumi_o` bit is set per cycle.

## Timing
- Reset values: `cfg_o` = `reset_val_p`, `resp_v_o`=0, `resp_id_o`=0, `resp_data_o`=0, `req_yumi_o`=0, state IDLE, priority pointer 0.
- Reset asserted mid-operation:
  - The in-flight request is dropped with no response and no register update.
  - Reset wins over a simultaneous COMMIT write.
- Latency, for a grant in cycle t:
  - Register updated at the end of t+1; `cfg_o` shows the new value in t+2.
  - `resp_v_o` is asserted in t+2.
- Throughput: one operation per 2 cycles when `resp_ready_i` is held high.
- READ ops have the same latency as other ops and leave `cfg_o` unchanged.
- `cfg_o` is registered output only; it has no bypass of pending values.

## Structure
- Shared backend package holds:
  - the op typedef (`bp_be_cfg_op_e`: WRITE/SET/CLEAR/READ)
  - the default reset-value and legal-mask constants, so the trap and debug logic use the same values
- Sub-module: the register itself is one `bsg_dff_reset_en` instance, with width `width_p`, reset value `reset_val_p`, and enable driven by COMMIT for non-READ ops.
- The round-robin arbiter is inline logic of about 20 lines and is not a separate module.

## Test plan
- Reset, then an idle cycle: `cfg_o`=64'h8000_0124, `resp_v_o`=0, `req_yumi_o`=0.
- Req0 WRITE 64'hDEAD_BEEF_0000_0001 with `resp_ready_i`=1:
  - yumi[0] in t
  - `resp_data_o`=64'h8000_0124 and `resp_id_o`=0 in t+2
  - `cfg_o`=64'hDEAD_BEEF_0000_0001 in t+2
- Req0 and req1 both held valid, each doing SET of a distinct bit (bit 0 and bit 1):
  - grants alternate 0,1,0,1
  - `cfg_o` ends at 64'h8000_0127
  - each response `id` matches its grant
- CLEAR 64'h0000_0000_8000_0000, then READ:
  - CLEAR response old=64'h8000_0124
  - READ response=64'h0000_0124
  - READ causes no `cfg_o` change
- `legal_mask_p`=64'h0000_0000_0000_00FF, WRITE 64'hFFFF_FFFF_FFFF_FF00: `cfg_o`=64'h8000_0100.
- Backpressure and reset:
  - Hold `resp_ready_i`=0 for 5 cycles with req1 valid: `resp_v_o` and data stay stable, no yumi.
  - Raise `resp_ready_i`: req1 is granted in the same cycle.
  - Assert reset during COMMIT: `cfg_o` returns to 64'h8000_0124 and no response appears.

Source files
------------

// File: rtl/bp_be_cfg_reg_ctrl_pkg.sv
// Shared backend definitions for the configuration register controller.
// Holds the request op encoding and the default reset value and legal-bit
// mask. Trap and debug logic import the same constants, so every agent agrees
// on what the register looks like after reset.
package bp_be_cfg_reg_ctrl_pkg;

  // Encoding of the two-bit per-requester op field
  typedef enum logic [1:0] {
    e_cfg_write = 2'd0,
    e_cfg_set   = 2'd1,
    e_cfg_clear = 2'd2,
    e_cfg_read  = 2'd3
  } bp_be_cfg_op_e;

  // Controller sequencing: accept a request, apply it, present the response
  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_commit = 2'd1,
    e_resp   = 2'd2
  } bp_be_cfg_state_e;

  localparam logic [63:0] bp_be_cfg_reset_val_gp  = 64'h0000_0000_8000_0124;
  localparam logic [63:0] bp_be_cfg_legal_mask_gp = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled D flip-flop bank with a synchronous, active-high reset to a
// parameterised value. Reset has priority over the enable.
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset, loads reset_val_p
//   en_i    - load enable for data_i
//   data_i  - next value
//   data_o  - registered value
module bsg_dff_reset_en #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r <= reset_val_p;
    end else if (en_i) begin
      data_r <= data_i;
    end
  end

  assign data_o = data_r;

endmodule

// File: rtl/bp_be_cfg_reg_ctrl.sv
// Arbitrated read-modify-write controller for one backend configuration
// register. Requesters issue WRITE/SET/CLEAR/READ; one is granted at a time
// in round-robin order, the op is applied under the legal-bit mask, and the
// pre-update value is returned (CSR-instruction semantics).
// Ports:
//   clk_i        - clock
//   reset_i      - synchronous active-high reset
//   req_v_i      - per-requester request valid
//   req_op_i     - per-requester 2-bit op (WRITE/SET/CLEAR/READ)
//   req_data_i   - per-requester operand
//   req_yumi_o   - one-hot grant; requester advances on the next cycle
//   resp_v_o     - response valid
//   resp_id_o    - index of the requester the response belongs to
//   resp_data_o  - register value before the operation
//   resp_ready_i - response consumer ready
//   cfg_o        - current register value
module bp_be_cfg_reg_ctrl
  import bp_be_cfg_reg_ctrl_pkg::*;
#(
  parameter int                 width_p      = 64,
  parameter int                 num_req_p    = 2,
  parameter logic [width_p-1:0] reset_val_p  = width_p'(bp_be_cfg_reset_val_gp),
  parameter logic [width_p-1:0] legal_mask_p = width_p'(bp_be_cfg_legal_mask_gp)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           req_v_i,
  input  logic [2*num_req_p-1:0]         req_op_i,
  input  logic [width_p*num_req_p-1:0]   req_data_i,
  output logic [num_req_p-1:0]           req_yumi_o,
  output logic                           resp_v_o,
  output logic [$clog2(num_req_p)-1:0]   resp_id_o,
  output logic [width_p-1:0]             resp_data_o,
  input  logic                           resp_ready_i,
  output logic [width_p-1:0]             cfg_o
);

  localparam int id_width_lp = $clog2(num_req_p);

  bp_be_cfg_state_e       state_r, state_n;
  logic [id_width_lp-1:0] ptr_r, grant_id, id_r, resp_id_r;
  bp_be_cfg_op_e          op_r;
  logic [width_p-1:0]     data_r, resp_data_r;
  logic [width_p-1:0]     cfg, nxt, cfg_n;
  logic                   grant_v, accept, take, cfg_en;

  // Round-robin pick: scan requesters starting at the priority pointer.
  // Only req_v_i feeds this, so yumi never depends on op or data.
  always_comb begin
    int idx;
    idx      = 0;
    grant_v  = 1'b0;
    grant_id = '0;
    for (int off = 0; off < num_req_p; off++) begin
      idx = (int'(ptr_r) + off) % num_req_p;
      if (!grant_v && req_v_i[idx]) begin
        grant_v  = 1'b1;
        grant_id = id_width_lp'(idx);
      end
    end
  end

  // A new request is accepted when idle, or when the current response is
  // being consumed this cycle (back-to-back operation).
  assign accept = (state_r == e_idle) || ((state_r == e_resp) && resp_ready_i);
  assign take   = accept && grant_v;

  always_comb begin
    req_yumi_o = '0;
    if (take) begin
      req_yumi_o[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:   if (take) state_n = e_commit;
      e_commit: state_n = e_resp;
      e_resp:   if (resp_ready_i) state_n = take ? e_commit : e_idle;
      default:  state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      ptr_r       <= '0;
      op_r        <= e_cfg_read;
      id_r        <= '0;
      resp_id_r   <= '0;
      resp_data_r <= '0;
    end else begin
      state_r <= state_n;
      if (take) begin
        op_r   <= bp_be_cfg_op_e'(req_op_i[grant_id*2 +: 2]);
        data_r <= req_data_i[grant_id*width_p +: width_p];
        id_r   <= grant_id;
        ptr_r  <= (grant_id == id_width_lp'(num_req_p-1)) ? '0 : grant_id + 1'b1;
      end
      // Response fields change only on COMMIT, so they stay frozen while a
      // response waits for resp_ready_i.
      if (state_r == e_commit) begin
        resp_data_r <= cfg;
        resp_id_r   <= id_r;
      end
    end
  end

  always_comb begin
    case (op_r)
      e_cfg_write: nxt = data_r;
      e_cfg_set:   nxt = cfg | data_r;
      e_cfg_clear: nxt = cfg & ~data_r;
      default:     nxt = cfg;
    endcase
    // Bits outside the legal mask keep their current (reset) value
    cfg_n = (cfg & ~legal_mask_p) | (nxt & legal_mask_p);
  end

  assign cfg_en = (state_r == e_commit) && (op_r != e_cfg_read);

  bsg_dff_reset_en #(
    .width_p     (width_p),
    .reset_val_p (reset_val_p)
  ) cfg_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (cfg_en),
    .data_i  (cfg_n),
    .data_o  (cfg)
  );

  assign resp_v_o    = (state_r == e_resp);
  assign resp_id_o   = resp_id_r;
  assign resp_data_o = resp_data_r;
  assign cfg_o       = cfg;

endmodule

// File: tb/tb_bp_be_cfg_reg_ctrl.sv
// Self-checking bench for bp_be_cfg_reg_ctrl: directed steps followed by a
// randomized phase checked against a transaction-level reference model.
module tb_bp_be_cfg_reg_ctrl;

  localparam logic [1:0]  OP_WRITE = 2'd0;
  localparam logic [1:0]  OP_SET   = 2'd1;
  localparam logic [1:0]  OP_CLEAR = 2'd2;
  localparam logic [1:0]  OP_READ  = 2'd3;
  localparam logic [63:0] RST_VAL  = 64'h0000_0000_8000_0124;
  localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_v = '0;
  logic [3:0]   req_op = '0;
  logic [127:0] req_data = '0;
  logic [1:0]   yumi;
  logic         resp_v;
  logic [0:0]   resp_id;
  logic [63:0]  resp_data;
  logic         resp_ready = 1'b1;
  logic [63:0]  cfg;

  logic [1:0]   b_req_v = '0;
  logic [3:0]   b_req_op = '0;
  logic [127:0] b_req_data = '0;
  logic [1:0]   b_yumi;
  logic         b_resp_v;
  logic [0:0]   b_resp_id;
  logic [63:0]  b_resp_data;
  logic         b_resp_ready = 1'b1;
  logic [63:0]  b_cfg;

  int checks = 0;
  int failures = 0;
  logic [63:0] model_cfg;

  always #5 clk = ~clk;

  bp_be_cfg_reg_ctrl dut (
    .clk_i(clk), .reset_i(reset), .req_v_i(req_v), .req_op_i(req_op),
    .req_data_i(req_data), .req_yumi_o(yumi), .resp_v_o(resp_v),
    .resp_id_o(resp_id), .resp_data_o(resp_data), .resp_ready_i(resp_ready),
    .cfg_o(cfg)
  );

  bp_be_cfg_reg_ctrl #(.legal_mask_p(64'h0000_0000_0000_00FF)) dut_mask (
    .clk_i(clk), .reset_i(reset), .req_v_i(b_req_v), .req_op_i(b_req_op),
    .req_data_i(b_req_data), .req_yumi_o(b_yumi), .resp_v_o(b_resp_v),
    .resp_id_o(b_resp_id), .resp_data_o(b_resp_data), .resp_ready_i(b_resp_ready),
    .cfg_o(b_cfg)
  );

  function automatic logic [63:0] apply(input logic [63:0] old, input logic [1:0] op,
                                        input logic [63:0] d, input logic [63:0] mask);
    logic [63:0] nv;
    case (op)
      OP_WRITE: nv = d;
      OP_SET:   nv = old | d;
      OP_CLEAR: nv = old & ~d;
      default:  nv = old;
    endcase
    return (old & ~mask) | (nv & mask);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1; req_v = '0; b_req_v = '0; resp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_cfg = RST_VAL;
  endtask

  // One complete transaction on the main instance with resp_ready held high
  task automatic do_op(input int i, input logic [1:0] op, input logic [63:0] d,
                       output logic [63:0] rdata, output logic [63:0] cfg_after);
    logic [63:0] old;
    int gc, rc;
    bit got;
    @(posedge clk); #1;
    req_v[i] = 1'b1; req_op[i*2 +: 2] = op; req_data[i*64 +: 64] = d; resp_ready = 1'b1;
    got = 0; gc = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (yumi[i]) begin got = 1; gc = c; end
    end
    chk("op_granted", 64'(got), 64'd1);
    chk("op_grant_cycle", 64'(gc), 64'd0);
    old = model_cfg;
    model_cfg = apply(model_cfg, op, d, ALL1);
    @(posedge clk); #1;
    req_v[i] = 1'b0;
    got = 0; rc = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      rc++;
      if (resp_v) got = 1;
    end
    chk("op_resp_v", 64'(got), 64'd1);
    chk("op_resp_latency", 64'(rc), 64'd2);
    chk("op_resp_id", 64'(resp_id), 64'(i));
    chk("op_resp_data", resp_data, old);
    chk("op_cfg", cfg, model_cfg);
    rdata = resp_data;
    cfg_after = cfg;
  endtask

  initial begin
    logic [63:0] rd, ca, hold, pend_old, exp_cfg;
    logic [1:0]  exp_y, last_yumi;
    int grants[$];
    int resp_ids[$];
    int since, ptr, pend_id, g, idx;
    bit got, busy, exp_rv, can;

    // Reset, then an idle cycle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_cfg = RST_VAL;
    @(negedge clk);
    chk("reset_cfg", cfg, RST_VAL);
    chk("reset_resp_v", 64'(resp_v), 64'd0);
    chk("reset_yumi", 64'(yumi), 64'd0);
    chk("reset_resp_id", 64'(resp_id), 64'd0);
    chk("reset_resp_data", resp_data, 64'd0);

    // Single WRITE from requester 0
    do_op(0, OP_WRITE, 64'hDEAD_BEEF_0000_0001, rd, ca);
    chk("write_old", rd, RST_VAL);
    chk("write_cfg", ca, 64'hDEAD_BEEF_0000_0001);

    // Two requesters held valid: grants must alternate
    reset_dut();
    @(posedge clk); #1;
    req_op = {OP_SET, OP_SET};
    req_data = {64'h2, 64'h1};
    req_v = 2'b11;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("rr_onehot", 64'($countones(yumi) <= 1), 64'd1);
      if (resp_v) resp_ids.push_back(int'(resp_id));
      if (yumi != 2'b00) grants.push_back(yumi[1] ? 1 : 0);
      if (grants.size() == 4 && req_v != 2'b00) begin
        @(posedge clk); #1;
        req_v = 2'b00;
      end
    end
    chk("rr_grant_count", 64'(grants.size()), 64'd4);
    chk("rr_resp_count", 64'(resp_ids.size()), 64'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("rr_grant_order", 64'(grants[k]), 64'(k % 2));
    for (int k = 0; k < 4 && k < resp_ids.size() && k < grants.size(); k++)
      chk("rr_resp_id", 64'(resp_ids[k]), 64'(grants[k]));
    chk("rr_cfg", cfg, 64'h0000_0000_8000_0127);

    // CLEAR then READ
    reset_dut();
    do_op(0, OP_CLEAR, 64'h0000_0000_8000_0000, rd, ca);
    chk("clear_old", rd, RST_VAL);
    chk("clear_cfg", ca, 64'h0000_0000_0000_0124);
    do_op(1, OP_READ, ALL1, rd, ca);
    chk("read_data", rd, 64'h0000_0000_0000_0124);
    chk("read_cfg_unchanged", ca, 64'h0000_0000_0000_0124);

    // Legal-mask instance: only the low byte is writable
    @(posedge clk); #1;
    b_req_v = 2'b01; b_req_op = {OP_READ, OP_WRITE}; b_req_data[63:0] = 64'hFFFF_FFFF_FFFF_FF00;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); if (b_yumi[0]) got = 1; end
    chk("mask_granted", 64'(got), 64'd1);
    @(posedge clk); #1;
    b_req_v = 2'b00;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); if (b_resp_v) got = 1; end
    chk("mask_resp_v", 64'(got), 64'd1);
    chk("mask_resp_data", b_resp_data, RST_VAL);
    chk("mask_cfg", b_cfg, 64'h0000_0000_8000_0100);

    // Backpressure, same-cycle regrant, then reset during COMMIT
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_v = 2'b01; req_op[1:0] = OP_WRITE; req_data[63:0] = 64'h0123_4567_89AB_CDEF;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); if (yumi[0]) got = 1; end
    chk("bp_granted", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_v = 2'b10; req_op[3:2] = OP_SET; req_data[127:64] = 64'h0000_0001_0000_0000;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); if (resp_v) got = 1; end
    chk("bp_resp_v", 64'(got), 64'd1);
    hold = resp_data;
    chk("bp_resp_data", hold, 64'h0000_0000_0000_0124);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_v", 64'(resp_v), 64'd1);
      chk("bp_hold_data", resp_data, hold);
      chk("bp_hold_id", 64'(resp_id), 64'd0);
      chk("bp_no_yumi", 64'(yumi), 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_regrant", 64'(yumi), 64'b10);
    @(posedge clk); #1;
    reset = 1'b1; req_v = 2'b00;
    @(negedge clk);
    chk("bp_cfg_before_reset", cfg, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;
    reset = 1'b0;
    model_cfg = RST_VAL;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_commit_cfg", cfg, RST_VAL);
      chk("rst_commit_no_resp", 64'(resp_v), 64'd0);
      @(posedge clk); #1;
    end

    // Randomized traffic against a transaction-level model
    reset_dut();
    busy = 0; since = 0; ptr = 0; pend_id = 0; pend_old = '0; last_yumi = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] || last_yumi[i]) begin
          req_v[i] = ($urandom % 3) != 0;
          req_op[i*2 +: 2] = 2'($urandom % 4);
          req_data[i*64 +: 64] = {$urandom, $urandom};
        end
      end
      resp_ready = ($urandom % 4) != 0;
      @(negedge clk);
      if (busy) since++;
      exp_rv = busy && since >= 2;
      chk("rnd_resp_v", 64'(resp_v), 64'(exp_rv));
      if (exp_rv) begin
        chk("rnd_resp_id", 64'(resp_id), 64'(pend_id));
        chk("rnd_resp_data", resp_data, pend_old);
      end
      exp_cfg = (busy && since < 2) ? pend_old : model_cfg;
      chk("rnd_cfg", cfg, exp_cfg);
      can = !busy || (exp_rv && resp_ready);
      exp_y = '0;
      if (can) begin
        for (int off = 0; off < 2; off++) begin
          idx = (ptr + off) % 2;
          if (req_v[idx] && exp_y == 2'b00) exp_y[idx] = 1'b1;
        end
      end
      chk("rnd_yumi", 64'(yumi), 64'(exp_y));
      if (exp_rv && resp_ready) busy = 0;
      if (exp_y != 2'b00) begin
        g = exp_y[1] ? 1 : 0;
        busy = 1; since = 0; pend_id = g; pend_old = model_cfg;
        model_cfg = apply(model_cfg, req_op[g*2 +: 2], req_data[g*64 +: 64], ALL1);
        ptr = (g + 1) % 2;
      end
      last_yumi = yumi;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
